// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// ram_pkg : shared state encoding and default sizes for the RAM burst reader
// Revision: 1.0
// ============================================================================
package ram_pkg;

  localparam int ADDR_DEFAULT  = 10;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// ============================================================================
// stream_buf2 : 2-entry registered FIFO, push without backpressure, valid/ready pop
// Revision: 1.0
// ============================================================================
module stream_buf2
  import ram_pkg::*;
#(
  parameter int DW = WIDTH_DEFAULT + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          pop;

  // The producer only pushes when a slot is guaranteed, so no input ready exists.
  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          head_d = in_data;
        end else if (in_valid) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (in_valid) begin
            tail_d = in_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// ram_burst_reader : reads a wrapping burst from a 1-cycle-latency RAM into a stream
// Revision: 1.0
// ============================================================================
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int ADDR  = ADDR_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [ADDR-1:0]  cmd_len,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ADDR-1:0]  ram_addr,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam logic [ADDR-1:0] C_ONE = {{(ADDR-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;

  logic [1:0]      buf_count;
  logic [1:0]      occupancy;
  logic [WIDTH:0]  buf_out;
  logic            pop;
  logic            issue;

  assign pop       = m_valid & m_ready;
  assign occupancy = buf_count + {1'b0, inflight_q};

  // A read may issue when its word is sure to find a slot; a full buffer never takes one.
  always_comb begin
    issue = 1'b0;
    if (state_q == ISSUE) begin
      issue = (occupancy < 2'd2) ||
              ((occupancy == 2'd2) && pop && (buf_count != 2'd2));
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    inflight_d      = issue;
    inflight_last_d = issue && (cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = addr_q + C_ONE;
          cnt_d  = cnt_q - C_ONE;
          if (cnt_q == '0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  stream_buf2 #(
    .DW (WIDTH + 1)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   ({inflight_last_q, ram_dout}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (buf_out),
    .count     (buf_count)
  );

  assign m_data    = buf_out[WIDTH-1:0];
  assign m_last    = m_valid & buf_out[WIDTH];
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ram_en    = issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_ram_burst_reader : directed bench with a queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_ram_burst_reader;

  localparam int ADDR  = 10;
  localparam int WIDTH = 8;
  localparam int DEPTH = 1 << ADDR;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ADDR-1:0]  cmd_addr  = '0;
  logic [ADDR-1:0]  cmd_len   = '0;
  logic             ram_en;
  logic             ram_we;
  logic [ADDR-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_dout  = '0;
  logic             m_valid;
  logic             m_ready   = 1'b1;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;

  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ram_burst_reader #(.ADDR(ADDR), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected addresses/words per accepted command, plus buffer occupancy
  logic [WIDTH:0]  exp_q[$];
  logic [ADDR-1:0] exp_addr_q[$];
  logic [WIDTH:0]  log_q[$];
  logic [WIDTH:0]  want[$];
  int              xfer_cyc[$];
  int              iss_cyc[$];
  int              acc_cyc[$];
  int              entered  = 0;
  int              xfers    = 0;
  bit              inflight = 1'b0;
  bit              active   = 1'b0;
  bit              stalled  = 1'b0;
  logic [WIDTH:0]  held     = '0;

  always @(negedge clk) begin
    int buffered;
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      entered  = 0;
      xfers    = 0;
      inflight = 1'b0;
      active   = 1'b0;
      stalled  = 1'b0;
    end else begin
      buffered = entered - xfers;
      check("ram_we", ram_we, 0);
      check("m_valid", m_valid, buffered > 0);
      check("busy", busy, active);
      check("cmd_ready", cmd_ready, !active);
      if (stalled) check("hold_stable", {m_valid, m_last, m_data}, {1'b1, held});
      if (ram_en) begin
        iss_cyc.push_back(cyc);
        check("ram_en_buf_full", buffered >= 2, 0);
        if (exp_addr_q.size() == 0) check("ram_en_outside_burst", ram_en, 0);
        else check("ram_addr", ram_addr, exp_addr_q.pop_front());
      end
      if (m_valid && m_ready) begin
        log_q.push_back({m_last, m_data});
        xfer_cyc.push_back(cyc);
        xfers++;
        if (exp_q.size() == 0) check("extra_word", m_valid, 0);
        else check("word", {m_last, m_data}, exp_q.pop_front());
        if (m_last) active = 1'b0;
      end
      stalled = m_valid && !m_ready;
      held    = {m_last, m_data};
      if (cmd_valid && cmd_ready) begin
        acc_cyc.push_back(cyc);
        active = 1'b1;
        for (int k = 0; k <= int'(cmd_len); k++) begin
          logic [ADDR-1:0] a;
          a = cmd_addr + ADDR'(k);
          exp_addr_q.push_back(a);
          exp_q.push_back({(k == int'(cmd_len)), mem[a]});
        end
      end
      // A read issued last cycle lands in the buffer at this cycle's closing edge
      entered += int'(inflight);
      inflight = ram_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_q.delete();
    xfer_cyc.delete();
    iss_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input logic [ADDR-1:0] a, input logic [ADDR-1:0] l);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    check("cmd_accept_timeout", ok, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check("idle_timeout", done, 1);
    tick();
  endtask

  task automatic expect_words(input string tag);
    check({tag, "_count"}, log_q.size(), want.size());
    foreach (want[k]) if (k < log_q.size()) check(tag, log_q[k], want[k]);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 7 + (i >> 8) * 50 + 3);

    // Reset values
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    tick();

    // Basic burst: ram_en one edge after acceptance, m_valid two edges after, then 1/cycle
    clear_logs();
    send(10'h010, 10'd3);
    wait_idle();
    want = '{9'h073, 9'h07A, 9'h081, 9'h188};
    expect_words("t1_word");
    for (int k = 0; k < 4; k++) begin
      if (k < iss_cyc.size() && acc_cyc.size() > 0)
        check("t1_issue_cycle", iss_cyc[k] - acc_cyc[0], 1 + k);
      if (k < xfer_cyc.size() && acc_cyc.size() > 0)
        check("t1_xfer_cycle", xfer_cyc[k] - acc_cyc[0], 3 + k);
    end

    // Address wrap inside a burst
    clear_logs();
    send(10'h3FE, 10'd3);
    wait_idle();
    want = '{9'h08B, 9'h092, 9'h003, 9'h10A};
    expect_words("t2_wrap");

    // Single-word burst
    clear_logs();
    send(10'h005, 10'd0);
    wait_idle();
    check("t3_ram_en_pulses", iss_cyc.size(), 1);
    want = '{9'h126};
    expect_words("t3_single");

    // Backpressure: 5-cycle stall then alternating ready
    clear_logs();
    m_ready = 1'b0;
    send(10'h020, 10'd7);
    for (int i = 0; i < 100 && (busy || exp_q.size() != 0); i++) begin
      m_ready = (i < 5) ? 1'b0 : (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    wait_idle();
    want = '{9'h0E3, 9'h0EA, 9'h0F1, 9'h0F8, 9'h0FF, 9'h006, 9'h00D, 9'h114};
    expect_words("t4_stall");

    // Reset while the third word is presented, then a fresh burst
    clear_logs();
    send(10'h040, 10'd7);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (log_q.size() >= 2) ok = 1'b1;
    end
    check("t5_reach_word3", ok, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_m_valid", m_valid, 0);
    check("t5_ram_en", ram_en, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    tick();
    clear_logs();
    send(10'h100, 10'd1);
    wait_idle();
    want = '{9'h035, 9'h13C};
    expect_words("t5_after_rst");

    // Command held valid across a burst: second accepted the cycle after m_last transfers
    clear_logs();
    cmd_valid = 1'b1;
    cmd_addr  = 10'h080;
    cmd_len   = 10'd2;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    check("t6_first_accept", ok, 1);
    tick();
    cmd_addr = 10'h090;
    cmd_len  = 10'd1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    check("t6_second_accept", ok, 1);
    tick();
    cmd_valid = 1'b0;
    wait_idle();
    check("t6_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() >= 2 && xfer_cyc.size() >= 3)
      check("t6_accept_after_last", acc_cyc[1] - xfer_cyc[2], 1);
    want = '{9'h083, 9'h08A, 9'h191, 9'h0F3, 9'h1FA};
    expect_words("t6_back_to_back");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
